// File: rtl/twiddle_mult36_pkg.sv
// Shared FFT constants for the 36-point (6x6) transform and the twiddle stage
// that sits between the two radix-6 passes.
//   N        : transform length
//   RADIX    : radix of each pass (N = RADIX * RADIX)
//   TW_WIDTH : signed twiddle width
//   TW_FRAC  : twiddle fraction bits (Q10, 1024 = 1.0)
//   IDX_W    : width of a sample index / twiddle number (0..N-1)
package twiddle_mult36_pkg;

  localparam int N        = 36;
  localparam int RADIX    = 6;
  localparam int TW_WIDTH = 18;
  localparam int TW_FRAC  = 10;
  localparam int IDX_W    = 6;

endpackage

// File: rtl/twiddle_mult36_if.sv
// Sample stream bundle for twiddle_mult36.
//   di_en, di_re, di_im : input sample stream (driven by the master)
//   do_en, do_re, do_im, do_first : twiddled output stream (driven by the slave)
//
// Handshake: valid-only streaming, no ready. A sample is transferred on every
// rising clock edge where its *_en bit is high; the data fields are don't-care
// on cycles where *_en is low. The consumer must take every valid sample, so
// there is no backpressure anywhere on this bundle.
interface twiddle_mult36_if #(
  parameter int WIDTH = 16
);

  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic             do_first;

  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im, do_first
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im, do_first
  );

endinterface

// File: rtl/twiddle_mult36_rom.sv
// Twiddle36 table: W36^k = exp(-j*2*pi*k/36) in Q10, 18-bit signed parts.
//   clk   : clock (used only when TW_FF = 1)
//   addr  : twiddle number k (0..35)
//   tw_re : round(1024 * cos(2*pi*k/36))
//   tw_im : round(-1024 * sin(2*pi*k/36))
// With TW_FF = 1 the outputs are registered, giving one cycle of latency.
module twiddle_mult36_rom
  import twiddle_mult36_pkg::*;
#(
  parameter bit TW_FF = 1'b1
) (
  input  logic                       clk,
  input  logic [IDX_W-1:0]           addr,
  output logic signed [TW_WIDTH-1:0] tw_re,
  output logic signed [TW_WIDTH-1:0] tw_im
);

  logic signed [TW_WIDTH-1:0] lut_re;
  logic signed [TW_WIDTH-1:0] lut_im;

  always_comb begin
    lut_re = '0;
    lut_im = '0;
    case (addr)
      6'd0:  {lut_re, lut_im} = { 18'sd1024,  18'sd0};
      6'd1:  {lut_re, lut_im} = { 18'sd1008, -18'sd178};
      6'd2:  {lut_re, lut_im} = { 18'sd962,  -18'sd350};
      6'd3:  {lut_re, lut_im} = { 18'sd887,  -18'sd512};
      6'd4:  {lut_re, lut_im} = { 18'sd784,  -18'sd658};
      6'd5:  {lut_re, lut_im} = { 18'sd658,  -18'sd784};
      6'd6:  {lut_re, lut_im} = { 18'sd512,  -18'sd887};
      6'd7:  {lut_re, lut_im} = { 18'sd350,  -18'sd962};
      6'd8:  {lut_re, lut_im} = { 18'sd178,  -18'sd1008};
      6'd9:  {lut_re, lut_im} = { 18'sd0,    -18'sd1024};
      6'd10: {lut_re, lut_im} = {-18'sd178,  -18'sd1008};
      6'd11: {lut_re, lut_im} = {-18'sd350,  -18'sd962};
      6'd12: {lut_re, lut_im} = {-18'sd512,  -18'sd887};
      6'd13: {lut_re, lut_im} = {-18'sd658,  -18'sd784};
      6'd14: {lut_re, lut_im} = {-18'sd784,  -18'sd658};
      6'd15: {lut_re, lut_im} = {-18'sd887,  -18'sd512};
      6'd16: {lut_re, lut_im} = {-18'sd962,  -18'sd350};
      6'd17: {lut_re, lut_im} = {-18'sd1008, -18'sd178};
      6'd18: {lut_re, lut_im} = {-18'sd1024,  18'sd0};
      6'd19: {lut_re, lut_im} = {-18'sd1008,  18'sd178};
      6'd20: {lut_re, lut_im} = {-18'sd962,   18'sd350};
      6'd21: {lut_re, lut_im} = {-18'sd887,   18'sd512};
      6'd22: {lut_re, lut_im} = {-18'sd784,   18'sd658};
      6'd23: {lut_re, lut_im} = {-18'sd658,   18'sd784};
      6'd24: {lut_re, lut_im} = {-18'sd512,   18'sd887};
      6'd25: {lut_re, lut_im} = {-18'sd350,   18'sd962};
      6'd26: {lut_re, lut_im} = {-18'sd178,   18'sd1008};
      6'd27: {lut_re, lut_im} = { 18'sd0,     18'sd1024};
      6'd28: {lut_re, lut_im} = { 18'sd178,   18'sd1008};
      6'd29: {lut_re, lut_im} = { 18'sd350,   18'sd962};
      6'd30: {lut_re, lut_im} = { 18'sd512,   18'sd887};
      6'd31: {lut_re, lut_im} = { 18'sd658,   18'sd784};
      6'd32: {lut_re, lut_im} = { 18'sd784,   18'sd658};
      6'd33: {lut_re, lut_im} = { 18'sd887,   18'sd512};
      6'd34: {lut_re, lut_im} = { 18'sd962,   18'sd350};
      6'd35: {lut_re, lut_im} = { 18'sd1008,  18'sd178};
      default: {lut_re, lut_im} = {18'sd0, 18'sd0};
    endcase
  end

  if (TW_FF) begin : g_ff
    always_ff @(posedge clk) begin
      tw_re <= lut_re;
      tw_im <= lut_im;
    end
  end else begin : g_comb
    assign tw_re = lut_re;
    assign tw_im = lut_im;
  end

endmodule

// File: rtl/twiddle_mult36.sv
// Inter-pass twiddle multiplier for a 36-point 6x6 FFT.
// Sample i of each frame is multiplied by W36^k, k = (i div 6) * (i mod 6),
// rounded (Q10, half toward +inf) and saturated to WIDTH bits.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of twiddle_mult36_if (di_* in, do_* out)
// Latency is 3 cycles from the accepting edge; one sample per cycle, no stall.
//   edge n   : capture sample, twiddle looked up from the stage-0 index
//   edge n+1 : four partial products
//   edge n+2 : complex sums
//   edge n+3 : round + saturate into the output registers
module twiddle_mult36
  import twiddle_mult36_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  twiddle_mult36_if.slave bus
);

  localparam int PROD_W = WIDTH + TW_WIDTH;
  localparam int SUM_W  = WIDTH + TW_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(64'sd1 <<< (TW_FRAC - 1));
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(-(64'sd1 <<< (WIDTH - 1)));

  // Stage 0: frame position as row/column of the 6x6 grid. k = row*col is
  // built by adding row once per column step, so no multiplier or divider is
  // needed; row*col never exceeds 25, so the mod-36 never has to wrap.
  logic [2:0]       row;
  logic [2:0]       col;
  logic [IDX_W-1:0] k;
  logic             s0_first;

  assign s0_first = (row == 3'd0) && (col == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      k   <= '0;
    end else if (bus.di_en) begin
      if (col == 3'(RADIX - 1)) begin
        col <= '0;
        k   <= '0;
        row <= (row == 3'(RADIX - 1)) ? 3'd0 : row + 3'd1;
      end else begin
        col <= col + 3'd1;
        k   <= k + IDX_W'(row);
      end
    end
  end

  // Twiddle is registered on the same edge that captures the sample.
  logic signed [TW_WIDTH-1:0] tw_re;
  logic signed [TW_WIDTH-1:0] tw_im;

  twiddle_mult36_rom #(
    .TW_FF (1'b1)
  ) u_rom (
    .clk   (clk),
    .addr  (k),
    .tw_re (tw_re),
    .tw_im (tw_im)
  );

  // Stage 1: sample register.
  logic                    s1_valid;
  logic                    s1_first;
  logic signed [WIDTH-1:0] s1_re;
  logic signed [WIDTH-1:0] s1_im;

  // Stage 2: partial products.
  logic                     s2_valid;
  logic                     s2_first;
  logic signed [PROD_W-1:0] p_ac;
  logic signed [PROD_W-1:0] p_bd;
  logic signed [PROD_W-1:0] p_ad;
  logic signed [PROD_W-1:0] p_bc;

  // Stage 3: full-precision complex result.
  logic                    s3_valid;
  logic                    s3_first;
  logic signed [SUM_W-1:0] sum_re;
  logic signed [SUM_W-1:0] sum_im;

  // Only the valid/first bits need reset; the data path is qualified by them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
    end else begin
      s1_valid <= bus.di_en;
      s1_first <= s0_first;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s3_valid <= s2_valid;
      s3_first <= s2_first;
    end
  end

  always_ff @(posedge clk) begin
    s1_re  <= bus.di_re;
    s1_im  <= bus.di_im;
    p_ac   <= PROD_W'(s1_re) * PROD_W'(tw_re);
    p_bd   <= PROD_W'(s1_im) * PROD_W'(tw_im);
    p_ad   <= PROD_W'(s1_re) * PROD_W'(tw_im);
    p_bc   <= PROD_W'(s1_im) * PROD_W'(tw_re);
    sum_re <= SUM_W'(p_ac) - SUM_W'(p_bd);
    sum_im <= SUM_W'(p_ad) + SUM_W'(p_bc);
  end

  function automatic logic [WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > MAX_V) return MAX_V[WIDTH-1:0];
    if (v < MIN_V) return MIN_V[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  // Round half toward +inf: add half an LSB, then floor via arithmetic shift.
  // With |twiddle| <= 1.0 the sums use far fewer than SUM_W bits, so the
  // rounding add cannot overflow.
  logic signed [SUM_W-1:0] rnd_re;
  logic signed [SUM_W-1:0] rnd_im;

  always_comb begin
    rnd_re = (sum_re + RND) >>> TW_FRAC;
    rnd_im = (sum_im + RND) >>> TW_FRAC;
  end

  // Output registers hold their last value while no sample is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.do_en    <= 1'b0;
      bus.do_first <= 1'b0;
      bus.do_re    <= '0;
      bus.do_im    <= '0;
    end else begin
      bus.do_en <= s3_valid;
      if (s3_valid) begin
        bus.do_first <= s3_first;
        bus.do_re    <= sat(rnd_re);
        bus.do_im    <= sat(rnd_im);
      end
    end
  end

endmodule

// File: doc/twiddle_mult36.md
TWIDDLE_MULT36 -- requirements
Module: twiddle_mult36

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the signed two's-complement data width of the input and output samples.
REQ-002 SHALL have port clk, input, 1 bit, the single master clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset, synchronous and active-low.
REQ-004 SHALL have port di_en, input, 1 bit, input sample valid.
REQ-005 SHALL have ports di_re and di_im, input, WIDTH bits each, the input sample (real, imag).
REQ-006 SHALL have port do_en, output, 1 bit, output sample valid.
REQ-007 SHALL have ports do_re and do_im, output, WIDTH bits each, the twiddled sample (real, imag).
REQ-008 SHALL have port do_first, output, 1 bit, high with the output sample of frame index 0.

Function
REQ-009 SHALL keep a sample index i (0..35) that increments by 1 only on cycles with di_en=1, and wraps 35->0.
REQ-010 SHALL derive twiddle number k = ((i div 6) * (i mod 6)) mod 36, for the 6x6 decomposition between the two radix-6 passes.
REQ-011 SHALL use 18-bit twiddles in Q10 format (1024 = 1.0), matching the 36-entry W36^k table.
REQ-012 SHALL compute re = a*c - b*d and im = a*d + b*c, where (a,b) is the input sample and (c,d) is the twiddle; products are WIDTH+18 bits and sums are WIDTH+19 bits, with no intermediate truncation.
REQ-013 SHALL round each result by adding 512 and then arithmetic-shifting right by 10 (round half toward +inf).
REQ-014 SHALL saturate each rounded result to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-015 SHALL have a fixed latency of 3 cycles: a sample accepted at edge n appears with do_en=1 after edge n+3.
REQ-016 SHALL have no backpressure; gaps in di_en SHALL reproduce identically as gaps in do_en, and the pipeline SHALL accept one sample per cycle.
REQ-017 SHALL pass k=0 samples through bit-exact, since (x*1024+512)>>>10 = x.
REQ-018 SHALL hold do_re, do_im and do_first at their last values while do_en=0.

Reset
REQ-019 On rst_n=0 at a clock edge, SHALL clear i to 0, clear all pipeline valid bits, and set do_en, do_first, do_re and do_im to 0.
REQ-020 On reset mid-frame, SHALL discard all in-flight samples (no do_en for them), and the first di_en after release SHALL use i=0.
REQ-021 SHALL ignore di_en while rst_n=0.

Structure
REQ-022 SHALL place the constants N=36, TW_WIDTH=18, TW_FRAC=10 and RADIX=6 in the shared FFT package.
REQ-023 SHALL instantiate the Twiddle36 table as its one sub-module with TW_FF=1: the address is driven combinationally from the stage-0 index, and the twiddle is registered in step with the data at stage 1.
REQ-024 SHALL compute k from the index with a 36-entry constant lookup or an incremental row/column counter; no runtime divider.

Verification
REQ-025 Reset scenario: hold rst_n=0 for 5 cycles with di_en toggling -> do_en=0, do_re=do_im=0, do_first=0 throughout.
REQ-026 Constant frame: 36 contiguous samples (1000,0) -> do_en high for 36 cycles starting 3 cycles later; i=0 gives (1000,0) with do_first=1; i=7 (k=1, tw=(1008,-178)) gives (984,-174).
REQ-027 Saturation: input (-32768,-32768) at i=21 (k=9, tw=(0,-1024)) -> output (-32768,32767).
REQ-028 Gapped input: 36 samples with di_en high every third cycle -> identical values to REQ-026, with do_en following the same gap pattern at 3-cycle latency.
REQ-029 Mid-frame reset: 10 samples, then rst_n=0 for 1 cycle, then 36 samples -> no outputs for the first 10; the next output has do_first=1 and k=0.
REQ-030 Wrap: 72 contiguous random samples -> do_first at output 0 and output 36 only; all outputs match a bit-accurate reference model using k from REQ-010.
